// File: rtl/mult_pkg.sv
// Shared constants and helpers for the multiplier arbiter slice.
package mult_pkg;

  localparam int N_DEF    = 32;
  localparam int NREQ_DEF = 4;

  // ceil(log2(v)), clamped to 1 so an id field never collapses to zero width
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at the entry after ptr.
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                start;
  int                sel;
  logic              found;

  // Rotate the requests so the entry just after ptr lands at bit 0
  always_comb begin
    start = (int'(ptr) >= NREQ - 1) ? 0 : int'(ptr) + 1;
    dbl   = {req, req};
    rot   = NREQ'(dbl >> start);
  end

  // First set bit of the rotated vector, mapped back to a requester index
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sel   = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (en && !found && rot[k]) begin
        found = 1'b1;
        sel   = start + k;
        if (sel >= NREQ) sel = sel - NREQ;
      end
    end
    if (found) begin
      gnt = NREQ'(1) << sel;
      idx = IDW'(sel);
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one external multiplier between NREQ valid/ready requesters and
// returns each product on a single response bus tagged with the requester id.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int NREQ    = NREQ_DEF,
  parameter int MUL_LAT = 0,
  parameter int IDW     = clog2_min1(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [N-1:0]      mul_a,
  output logic [N-1:0]      mul_b,
  input  logic [2*N-1:0]    mul_p,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*N-1:0]    rsp_p,
  output logic              busy
);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            arb_en;
  logic            fire;
  logic [N-1:0]    sel_a;
  logic [N-1:0]    sel_b;
  tag_t            issue_tag;
  tag_t            pipe_end;
  logic            pipe_busy;

  assign arb_en = ~rst & ~hold;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign fire      = |(req_valid & gnt);

  // One-hot operand mux driven by the grant vector
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*N +: N];
        sel_b = req_b[i*N +: N];
      end
    end
  end

  // Round-robin pointer moves to the winner only when a handshake completes
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IDW'(NREQ - 1);
    end else if (fire) begin
      ptr <= gnt_idx;
    end
  end

  // Issue stage: operands hold between handshakes, the tag valid is a pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a     <= '0;
      mul_b     <= '0;
      issue_tag <= '0;
    end else begin
      issue_tag.vld <= fire;
      if (fire) begin
        mul_a        <= sel_a;
        mul_b        <= sel_b;
        issue_tag.id <= gnt_idx;
      end
    end
  end

  generate
    if (MUL_LAT == 0) begin : g_no_pipe
      assign pipe_end  = issue_tag;
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      tag_t stage [MUL_LAT];

      // Tags shift in lockstep with the multiplier registers and never stall
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < MUL_LAT; s++) stage[s] <= '0;
        end else begin
          stage[0] <= issue_tag;
          for (int s = 1; s < MUL_LAT; s++) stage[s] <= stage[s-1];
        end
      end

      // Any valid tag still travelling through the multiplier
      always_comb begin
        pipe_busy = 1'b0;
        for (int s = 0; s < MUL_LAT; s++) pipe_busy = pipe_busy | stage[s].vld;
      end

      assign pipe_end = stage[MUL_LAT-1];
    end
  endgenerate

  // Response register captures the product when its tag reaches the pipe end
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else begin
      rsp_valid <= pipe_end.vld;
      if (pipe_end.vld) begin
        rsp_p  <= mul_p;
        rsp_id <= pipe_end.id;
      end
    end
  end

  assign busy = issue_tag.vld | pipe_busy | rsp_valid;

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one N-bit Wallace tree multiplier between NREQ requesters.
- Each requester uses a valid/ready handshake.
- A round-robin grant feeds a registered issue stage that drives the multiplier operand pins.
- A tag pipeline tracks each operation through the multiplier, and the product returns on a shared response bus tagged with the requester id.
- The block sits between the multiplier datapath and its client blocks; the multiplier is instantiated beside it, not inside it.

Parameters:
- N, 32, operand width; product width is 2N.
- NREQ, 4, number of requesters, 2..16.
- MUL_LAT, 0, register stages inside the multiplier (0 = combinational tree), 0..4.
- IDW, $clog2(NREQ), requester id width (derived; minimum 1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  when 1, no new grants; in-flight operations still drain.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_a  in  NREQ*N  flattened operand A; requester i occupies bits [i*N +: N].
- req_b  in  NREQ*N  flattened operand B, same layout as req_a.
- mul_a  out  N  operand A to multiplier.
- mul_b  out  N  operand B to multiplier.
- mul_p  in  2N  product from multiplier.
- rsp_valid  out  1  one-cycle pulse: rsp_p/rsp_id valid.
- rsp_id  out  IDW  requester index owning rsp_p.
- rsp_p  out  2N  unsigned product.
- busy  out  1  any operation in issue stage, tag pipe or response register.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - req_ready=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_p=0, busy=0.
  - Round-robin pointer = NREQ-1, so requester 0 has top priority first.
  - All tag-pipe valid bits = 0.
- Arbitration (combinational):
  - When rst=0 and hold=0, grant the first i with req_valid[i]=1, searching from ptr+1 upward modulo NREQ.
  - req_ready = one-hot grant. req_ready depends combinationally on req_valid; requesters must not make valid depend on ready.
  - Handshake = req_valid[i] & req_ready[i] at the rising edge. ptr updates to the granted index only on a handshake.
  - Requesters must hold valid and operands stable until the handshake.
- Throughput: one handshake per cycle maximum; back-to-back issue with no bubbles.
- Issue stage:
  - On a handshake, mul_a/mul_b load req_a/req_b of the winner; the issue tag takes {1, id}.
  - With no handshake, mul_a/mul_b hold their value and the tag valid bit clears.
- Tag pipe:
  - MUL_LAT stages of {valid, id} shift every cycle.
  - The pipe never stalls: there is no response backpressure, so consumers must accept rsp_valid immediately.
- Response register:
  - Loads rsp_p = mul_p and rsp_id = tag id when the tag at the pipe end is valid; rsp_valid = that valid bit.
  - When no valid tag arrives, rsp_valid=0 and rsp_p/rsp_id hold their value.
- Latency: handshake in cycle c, rsp_valid high in cycle c+2+MUL_LAT, exactly one cycle per operation. Response order = grant order.
- busy: OR of the issue valid, all tag-pipe valids and rsp_valid.
- hold=1:
  - req_ready=0 the same cycle; ptr is unchanged.
  - Outstanding results still appear at their normal latency.
- Reset mid-operation: all in-flight operations are discarded, no rsp_valid for them, and the pointer returns to NREQ-1.
- Width: operands are unsigned; the product is taken as the full 2N bits with no truncation.
- Edge cases:
  - NREQ=1 is not supported.
  - A requester may re-request the cycle after its handshake; it still yields to other waiting requesters through the pointer.

Decomposition:
- Package mult_pkg:
  - Constants N_DEF, NREQ_DEF.
  - Function clog2_min1.
  - Typedef tag_t {logic vld; logic [IDW-1:0] id}. This is parameter-dependent, so it is declared in the module via IDW; the package holds the function only.
- Sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs: req, ptr, en. Output: one-hot gnt, idx.
  - Purely combinational; the double-width rotate-and-priority method is natural.
- mult_arbiter holds the pointer register, issue stage, tag pipe and response register.

Test Plan:
1. Single request, MUL_LAT=0: req 2 with a=0x0000_FFFF, b=0x0001_0000 at cycle 5. Expect req_ready[2]=1 in cycle 5, mul_a=0x0000FFFF in cycle 6, rsp_valid in cycle 7 with rsp_id=2 and rsp_p=0x0000_0000_FFFF_0000, busy 0 by cycle 8.
2. All four requesting continuously, MUL_LAT=2: grants go 0,1,2,3,0,… one per cycle; responses arrive 4 cycles after each grant in the same id order. Max case a=b=0xFFFF_FFFF gives rsp_p=0xFFFF_FFFE_0000_0001.
3. Fairness: req 0 and req 3 always valid. Grants alternate 0,3,0,3; requesters 1/2 are never granted; no requester waits more than NREQ-1 cycles.
4. hold asserted for 3 cycles with 2 operations in flight (MUL_LAT=2): req_ready stays 0 during hold; both responses still appear at latency 4; after hold drops, the grant resumes at ptr+1.
5. rst asserted for 1 cycle with 3 operations in flight: no rsp_valid afterwards; busy=0 the cycle after reset; the next request from requester 1 (with req 0 also valid) grants requester 0 first.
6. Back-to-back same requester: req 1 alone valid for 4 cycles. 4 handshakes and 4 responses in consecutive cycles, with products matching each operand pair (e.g. 3*5=15, 7*9=63).
